mlp_fixed_seq: RTL and testbench
================================

// Module: mlp_fixed_seq
// PURPOSE
//  Parametrised, time-multiplexed two-layer fixed-point perceptron network (N_IN inputs,
//  N_HID hidden neurons, 1 output neuron, step activation) on one shared MAC.
//  Successor to the combinational fixed-point XOR network: same math, runtime-loadable
//  weights, streaming samples with valid/ready handshake. Sits between sample source and
//  classifier consumer.
// PARAMETERS
//  TAM    16  data/weight width, signed two's complement fixed point
//  FRAC    8  fractional bits (Q(TAM-FRAC).FRAC); ONE = 1<<FRAC
//  N_IN    2  inputs per sample
//  N_HID   2  hidden neurons
//  Derived: N_W = N_HID*(N_IN+1)+N_HID+1 weights; AW = $clog2(N_W)
// PORTS
//  clk      in   1          clock, all state on rising edge
//  rst_n    in   1          asynchronous, active-low reset
//  in_valid in   1          sample valid
//  in_ready out  1          block can accept a sample (state IDLE)
//  in_x     in   N_IN*TAM   sample; x[i] = in_x[i*TAM +: TAM]
//  out_valid out 1          result valid, held until out_ready
//  out_ready in  1          consumer accepts result
//  out_y    out  TAM        activation: ONE if acc>0 else 0
//  out_acc  out  TAM        output pre-activation, >>FRAC, saturated to TAM
//  w_we     in   1          weight write strobe
//  w_addr   in   AW         weight index
//  w_data   in   TAM        weight value
//  w_busy   out  1          1 when writes are being dropped (state != IDLE)
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, out_y=0, out_acc=0, w_busy=0, weights=0.
//  - Weight map: hidden j, term k (k=0 bias, k=i+1 for x[i]) at j*(N_IN+1)+k;
//    output term k (k=0 bias, k=j+1 for h[j]) at N_HID*(N_IN+1)+k.
//  - Weight write takes effect next edge, only in IDLE; when busy or w_addr>=N_W: dropped.
//  - FSM IDLE->HID->OUT->DONE->IDLE.
//    IDLE: in_valid&&in_ready latches in_x, clears acc, goes HID.
//    HID: one product/cycle, k=0..N_IN per neuron j=0..N_HID-1; after k=N_IN store
//         h[j]=(acc>0)?ONE:0, clear acc. Bias operand is ONE. Last neuron -> OUT.
//    OUT: k=0..N_HID over (ONE,h[]) with output weights; last term -> DONE.
//    DONE: out_valid=1, out_y/out_acc stable; out_valid&&out_ready -> IDLE.
//  - Latency: accept edge -> out_valid high = N_W+1 clocks (10 with defaults).
//    Throughput 1 sample per N_W+2 clocks minimum, no overlap.
//  - Arithmetic: full 2*TAM signed products, accumulated in ACC_W=2*TAM+$clog2(N_IN+N_HID+1)
//    bits, no intermediate rounding; activation tests sign of full acc (acc==0 -> 0).
//    out_acc = acc>>>FRAC (arith, toward -inf), clamped to [-2^(TAM-1), 2^(TAM-1)-1].
//  - in_ready=0 outside IDLE; in_valid there is ignored, in_x may change freely.
//  - Backpressure: DONE holds outputs indefinitely while out_ready=0.
//  - Reset mid-operation: immediate return to reset values, including weights; no output.
// STRUCTURE
//  - mlp_pkg: state enum (IDLE,HID,OUT,DONE), ONE/ACC_W/N_W helper functions,
//    step activation function.
//  - Sub-module mlp_mac: signed TAM x TAM multiply, ACC_W accumulate, clear/enable,
//    sign + saturated out_acc.
//  - Top: FSM, j/k counters, weight register file, sample/h[] latches.
// TESTING (Q8.8, defaults)
//  - XOR: load hid0={FF80,0100,0100}, hid1={0180,FF00,FF00}, out={FE80,0100,0100};
//    x=(0,0),(0,1),(1,0),(1,1) in 0x0100 units -> out_y=0,0x0100,0x0100,0; out_valid
//    exactly 10 clocks after each accept.
//  - Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid/out_y stable,
//    in_ready=0; release -> one transfer, in_ready=1 next cycle.
//  - Busy write: w_we at addr 0 during HID -> w_busy=1, weight unchanged, result equals
//    golden model.
//  - Out-of-range: w_addr=9..15 in IDLE -> no weight changes (readback via results).
//  - Saturation: all weights 0x7FFF, x=(0x7FFF,0x7FFF) -> out_acc=0x7FFF, out_y=0x0100;
//    all weights 0x8000 with x=(0x7FFF,0x7FFF) -> out_acc=0x8000.
//  - Reset mid-HID: rst_n low 1 cycle -> out_valid=0, in_ready=1, weights 0; next sample
//    -> out_y=0, out_acc=0.

Source files
------------

// File: rtl/mlp_fixed_seq_pkg.sv
// Shared types and helpers for the time-multiplexed fixed-point perceptron.
package mlp_fixed_seq_pkg;

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

    // Total weight count: hidden neurons with bias, then output neuron with bias.
    function automatic int calc_n_w(input int n_in, input int n_hid);
        return n_hid * (n_in + 1) + n_hid + 1;
    endfunction

    // Accumulator wide enough for the longest dot product without overflow.
    function automatic int calc_acc_w(input int tam, input int n_in, input int n_hid);
        return 2 * tam + $clog2(n_in + n_hid + 1);
    endfunction

    // Fixed-point 1.0 for the given number of fractional bits.
    function automatic int one_val(input int frac);
        return 1 << frac;
    endfunction

    // Step activation: strictly positive fires, zero does not.
    function automatic logic step(input logic neg, input logic zero);
        return !neg && !zero;
    endfunction

endpackage

// File: rtl/mlp_fixed_seq_if.sv
// Sample, result and weight-load signals of the perceptron block.
interface mlp_fixed_seq_if #(
    parameter int TAM  = 16,
    parameter int N_IN = 2,
    parameter int AW   = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [N_IN*TAM-1:0] in_x;
    logic                out_valid;
    logic                out_ready;
    logic [TAM-1:0]      out_y;
    logic [TAM-1:0]      out_acc;
    logic                w_we;
    logic [AW-1:0]       w_addr;
    logic [TAM-1:0]      w_data;
    logic                w_busy;

    modport master (
        output in_valid, in_x, out_ready, w_we, w_addr, w_data,
        input  in_ready, out_valid, out_y, out_acc, w_busy
    );

    modport slave (
        input  in_valid, in_x, out_ready, w_we, w_addr, w_data,
        output in_ready, out_valid, out_y, out_acc, w_busy
    );
endinterface

// File: rtl/mlp_fixed_seq_mac.sv
// Shared signed multiply-accumulate with step test and saturated Q-format readout.
module mlp_fixed_seq_mac
    import mlp_fixed_seq_pkg::*;
#(
    parameter int TAM   = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 35
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic signed [TAM-1:0] a,
    input  logic signed [TAM-1:0] b,
    output logic                  sum_pos,
    output logic                  acc_pos,
    output logic signed [TAM-1:0] acc_sat
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-TAM+1){1'b0}}, {(TAM-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-TAM+1){1'b1}}, {(TAM-1){1'b0}}};

    logic signed [2*TAM-1:0] prod;
    logic signed [ACC_W-1:0] acc, sum, shr;

    assign prod = a * b;
    assign sum  = acc + ACC_W'(prod);
    assign shr  = acc >>> FRAC;

    // sum_pos sees the term being added this cycle, so a neuron can fire on its last product
    assign sum_pos = step(sum[ACC_W-1], sum == '0);
    assign acc_pos = step(acc[ACC_W-1], acc == '0);

    // Clear wins over accumulate: closing a neuron and starting the next share one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= sum;
    end

    // Rescale to TAM bits and clamp to the representable range
    always_comb begin
        acc_sat = shr[TAM-1:0];
        if (shr > SAT_MAX)      acc_sat = SAT_MAX[TAM-1:0];
        else if (shr < SAT_MIN) acc_sat = SAT_MIN[TAM-1:0];
    end
endmodule

// File: rtl/mlp_fixed_seq.sv
// Two-layer step-activation perceptron evaluated one product per clock on a single MAC.
module mlp_fixed_seq
    import mlp_fixed_seq_pkg::*;
#(
    parameter int TAM   = 16,
    parameter int FRAC  = 8,
    parameter int N_IN  = 2,
    parameter int N_HID = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mlp_fixed_seq_if.slave  bus
);
    localparam int N_W   = calc_n_w(N_IN, N_HID);
    localparam int ACC_W = calc_acc_w(TAM, N_IN, N_HID);
    localparam int CW    = $clog2(N_IN + N_HID + 2);
    localparam int OBASE = N_HID * (N_IN + 1);
    localparam logic signed [TAM-1:0] ONE = TAM'(one_val(FRAC));

    state_t                    state, state_nxt;
    logic [CW-1:0]             j, k;
    logic [N_W-1:0][TAM-1:0]   w;
    logic [N_IN-1:0][TAM-1:0]  x;
    logic [N_HID-1:0]          h;
    logic                      mac_clr, mac_en, last_k, last_j;
    logic                      sum_pos, acc_pos;
    logic signed [TAM-1:0]     op_w, op_x, acc_sat;
    logic                      out_valid_q;
    logic [TAM-1:0]            out_y_q, out_acc_q;
    int                        wi, xi;

    assign last_k = (state == HID) ? (k == CW'(N_IN)) : (k == CW'(N_HID));
    assign last_j = (j == CW'(N_HID - 1));

    assign bus.in_ready  = (state == IDLE);
    assign bus.w_busy    = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_acc   = out_acc_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and MAC control
    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        unique case (state)
            IDLE: if (bus.in_valid) begin
                state_nxt = HID;
                mac_clr   = 1'b1;
            end
            HID: begin
                mac_en = 1'b1;
                if (last_k) begin
                    mac_clr = 1'b1;
                    if (last_j) state_nxt = OUT;
                end
            end
            OUT: begin
                mac_en = 1'b1;
                if (last_k) state_nxt = DONE;
            end
            DONE: if (out_valid_q && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Neuron (j) and term (k) counters; k restarts at 0 for every neuron and for the output layer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j <= '0;
            k <= '0;
        end else begin
            unique case (state)
                HID: if (last_k) begin
                    k <= '0;
                    j <= j + 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
                OUT: k <= k + 1'b1;
                default: begin
                    j <= '0;
                    k <= '0;
                end
            endcase
        end
    end

    // Operand select: term 0 is always the bias against ONE, term k>0 is input/hidden k-1
    always_comb begin
        wi   = (state == OUT) ? OBASE + int'(k) : int'(j) * (N_IN + 1) + int'(k);
        xi   = int'(k) - 1;
        op_w = '0;
        op_x = ONE;
        for (int i = 0; i < N_W; i++)   if (i == wi) op_w = w[i];
        for (int i = 0; i < N_IN; i++)  if (state == HID && i == xi) op_x = x[i];
        for (int i = 0; i < N_HID; i++) if (state == OUT && i == xi) op_x = h[i] ? ONE : '0;
    end

    // Weight file: writes only land in IDLE; addresses past the last weight match no entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w <= '0;
        else if (bus.w_we && state == IDLE)
            for (int i = 0; i < N_W; i++)
                if (int'(bus.w_addr) == i) w[i] <= bus.w_data;
    end

    // Sample latch on accept, hidden activations as each neuron closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            h <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) x <= bus.in_x;
            if (state == HID && last_k)
                for (int i = 0; i < N_HID; i++)
                    if (int'(j) == i) h[i] <= sum_pos;
        end
    end

    // Result register: captured one cycle into DONE so saturation stays off the accumulate path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_acc_q   <= '0;
        end else if (state == DONE && !out_valid_q) begin
            out_valid_q <= 1'b1;
            out_y_q     <= acc_pos ? ONE : '0;
            out_acc_q   <= acc_sat;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    mlp_fixed_seq_mac #(.TAM(TAM), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (op_w),
        .b       (op_x),
        .sum_pos (sum_pos),
        .acc_pos (acc_pos),
        .acc_sat (acc_sat)
    );
endmodule

// File: tb/tb_mlp_fixed_seq.sv
// Scoreboard bench for mlp_fixed_seq: driver pushes expected results, monitor pops on out_valid.
module tb_mlp_fixed_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlp_fixed_seq_if #(.TAM(16), .N_IN(2), .AW(4)) bus ();

    mlp_fixed_seq #(.TAM(16), .FRAC(8), .N_IN(2), .N_HID(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] y;
        logic [15:0] acc;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        holding = 1'b0;
    logic [15:0] hold_y, hold_acc;
    logic [15:0] xor_w [9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: first valid cycle is scored against the queue, held cycles must stay frozen
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_y", 32'(bus.out_y), 32'(hold_y));
                chk("hold_acc", 32'(bus.out_acc), 32'(hold_acc));
                chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got y=%h acc=%h expected none",
                             bus.out_y, bus.out_acc);
                end else begin
                    cur = exp_q.pop_front();
                    chk("out_y", 32'(bus.out_y), 32'(cur.y));
                    chk("out_acc", 32'(bus.out_acc), 32'(cur.acc));
                    chk("latency", 32'(cyc - cur.cyc), 32'd10);
                end
                holding  = 1'b1;
                hold_y   = bus.out_y;
                hold_acc = bus.out_acc;
            end
            if (bus.out_valid && bus.out_ready) holding = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready=%b expected 1", bus.in_ready);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data);
        wait_idle();
        bus.w_we   = 1'b1;
        bus.w_addr = addr;
        bus.w_data = data;
        tick();
        bus.w_we   = 1'b0;
    endtask

    task automatic load_xor();
        for (int i = 0; i < 9; i++) wr(4'(i), xor_w[i]);
    endtask

    task automatic load_all(input logic [15:0] v);
        for (int i = 0; i < 9; i++) wr(4'(i), v);
    endtask

    task automatic send(input logic [15:0] x0, input logic [15:0] x1,
                        input logic [15:0] y, input logic [15:0] acc, input bit push);
        exp_t t;
        wait_idle();
        bus.in_x     = {x1, x0};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_x     = 32'hDEAD_BEEF;
        t.y   = y;
        t.acc = acc;
        t.cyc = cyc;
        if (push) exp_q.push_back(t);
    endtask

    task automatic run_xor();
        send(16'h0000, 16'h0000, 16'h0000, 16'hFF80, 1'b1);
        send(16'h0000, 16'h0100, 16'h0100, 16'h0080, 1'b1);
        send(16'h0100, 16'h0000, 16'h0100, 16'h0080, 1'b1);
        send(16'h0100, 16'h0100, 16'h0000, 16'hFF80, 1'b1);
    endtask

    initial begin
        int n;
        xor_w = '{16'hFF80, 16'h0100, 16'h0100, 16'h0180, 16'hFF00, 16'hFF00,
                  16'hFE80, 16'h0100, 16'h0100};
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_y", 32'(bus.out_y), 32'd0);
        chk("rst_out_acc", 32'(bus.out_acc), 32'd0);
        chk("rst_w_busy", 32'(bus.w_busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // XOR truth table
        load_xor();
        run_xor();

        // Backpressure: result must sit still for 20 cycles
        wait_idle();
        bus.out_ready = 1'b0;
        send(16'h0000, 16'h0100, 16'h0100, 16'h0080, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (20) tick();
        bus.out_ready = 1'b1;
        tick();
        chk("bp_valid_after", 32'(bus.out_valid), 32'd0);
        chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Write while busy is dropped; following sample still uses the old bias
        send(16'h0100, 16'h0000, 16'h0100, 16'h0080, 1'b1);
        tick();
        tick();
        chk("busy_flag", 32'(bus.w_busy), 32'd1);
        bus.w_we   = 1'b1;
        bus.w_addr = 4'd0;
        bus.w_data = 16'h7FFF;
        tick();
        bus.w_we   = 1'b0;
        send(16'h0000, 16'h0000, 16'h0000, 16'hFF80, 1'b1);

        // Out-of-range addresses leave the weight file untouched
        for (int a = 9; a < 16; a++) wr(4'(a), 16'h7FFF);
        run_xor();

        // Saturation both ways
        load_all(16'h7FFF);
        send(16'h7FFF, 16'h7FFF, 16'h0100, 16'h7FFF, 1'b1);
        load_all(16'h8000);
        send(16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000, 1'b1);

        // Reset in the middle of HID wipes weights and produces no result
        send(16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_w_busy", 32'(bus.w_busy), 32'd0);
        chk("mid_rst_out_acc", 32'(bus.out_acc), 32'd0);
        rst_n = 1'b1;
        tick();
        send(16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b1);
        send(16'h0000, 16'h0100, 16'h0000, 16'h0000, 1'b1);

        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
